switch_allocator: RTL and testbench
===================================

# switch_allocator

Sequential output-port allocator for the 3-port router (X, Y, LOCAL). It arbitrates between the three input ports, each of which presents a 2-bit destination, and locks each output to one input for the duration of a packet (wormhole). Each output has its own round-robin arbiter. The block drives the crossbar select lines and the per-input ready and fail flags, and sits between the input buffers and the crossbar.

## Interface
- TIMEOUT, default 64: idle-lock watchdog limit in cycles. Used only when ALLOC_TIMEOUT_EN is defined. Legal range 1–255.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- in_valid  in  3  flit present; bit 2 = X, bit 1 = Y, bit 0 = LOCAL.
- in_dir_x, in_dir_y, in_dir_local  in  2 each  destination: 00 NONE, 01 X, 10 Y, 11 LOCAL.
- in_tail  in  3  current flit is the last of its packet.
- out_ready  in  3  downstream can accept a flit; bit 2 = X out, bit 1 = Y out, bit 0 = LOCAL out.
- in_ready  out  3  flit on that input transfers this cycle.
- out_valid  out  3  flit driven on that output this cycle.
- sel_x, sel_y, sel_local  out  2 each  crossbar source: 00 none, 01 X, 10 Y, 11 LOCAL.
- fail  out  3  in_valid set and in_ready clear, same bit order as in_valid.
- timeout_err  out  3  one-cycle pulse per output on forced release. Exists only with ALLOC_TIMEOUT_EN.

## Operation
- Each output runs a two-state FSM: IDLE and LOCKED. Each output also holds a registered owner (2-bit, sel encoding) and a round-robin pointer.
- **Requests in IDLE:**
  - Output o is requested by input i when in_valid[i] is set, in_dir_i equals o, and input i is not owner of any LOCKED output.
  - Destination 00 is never a request. Such an input has in_ready=0 and fail=1 while valid.
- **Arbitration in IDLE:**
  - Search order starts at the pointer and runs X→Y→LOCAL→X.
  - The first requester wins. On the next edge: state=LOCKED, owner=winner, pointer=input following the winner.
- **Transfer in LOCKED:**
  - out_valid[o] = in_valid[owner]; sel_o = owner; in_ready[owner] = out_ready[o].
  - in_dir is ignored while locked; the destination is sampled at the header flit only.
  - A transfer (in_valid & out_ready) with in_tail set returns the output to IDLE on the next edge.
- **Outputs in IDLE:** sel_o=00, out_valid=0.
- **Fail flag:** fail = in_valid & ~in_ready, per input, combinational. It covers both arbitration losers and inputs stalled by backpressure.
- **Simultaneous requests:** two or three inputs requesting one output get exactly one grant per allocation. The others see fail=1 until they win.
- Distinct outputs allocate independently in the same cycle.

## Timing
- **Reset values:** all FSMs IDLE, owners 00, pointers X.
  - in_ready=0, out_valid=0, sel_*=00, fail=in_valid (combinational), timeout_err=0.
- **Allocation latency:** a header valid at edge N locks at edge N+1. The first transfer can occur in cycle N+1.
- in_ready, out_valid, sel_* and fail are combinational from the registered state and the current inputs. There is no combinational path from in_dir to in_ready.
- **Single-flit packet** (header = tail): lock for one cycle, then IDLE.
- **Tail then new header to the same output:**
  - One bubble cycle (IDLE) follows the tail transfer.
  - The released owner is lowest priority in that arbitration.
- **Reset mid-packet:** locks are dropped immediately and asynchronously. The remaining flits of that packet are treated as new headers.
- The pointer advances only on a grant, never while LOCKED or idle.

## Configuration
- ALLOC_TIMEOUT_EN defined:
  - Each output has an 8-bit counter that is cleared on any transfer or on entry to LOCKED, and increments while LOCKED with no transfer because in_valid[owner]=0.
  - Stall caused by out_ready=0 does not count.
  - When the counter reaches TIMEOUT, the output is forced to IDLE on the next edge and timeout_err[o] pulses for one cycle.
- ALLOC_TIMEOUT_EN undefined: no counters and no timeout_err port. A lock is released only by a tail transfer or reset.

## Structure
- The shared package router_pkg holds:
  - direction/select constants DIR_NONE=00, DIR_X=01, DIR_Y=10, DIR_LOCAL=11;
  - port bit indices PORT_X=2, PORT_Y=1, PORT_LOCAL=0;
  - the FSM state enum {IDLE, LOCKED}.
- Sub-module rr_arb3 handles one output's round-robin choice: 3-bit request, 2-bit pointer → winner code plus a grant-valid flag. It is instantiated once per output.

## Test plan
- **Three-way contention:**
  - Stimulus: X, Y and LOCAL all send single-flit packets to Y out, with out_ready=111.
  - Required: grants occur in order X, Y, LOCAL on consecutive lock cycles. fail goes 011, then 001, then 000. sel_y goes 01, 10, 11.
- **Wormhole hold:**
  - Stimulus: X sends a 4-flit packet to LOCAL. At beat 2, Y requests LOCAL.
  - Required: sel_local stays 01 for all 4 beats. Y fail=1 throughout. Y is locked two cycles after X's tail.
- **Backpressure:**
  - Stimulus: a locked X→Y transfer with out_ready[1]=0 for 5 cycles.
  - Required: in_ready[2]=0, fail[2]=1, lock held. Transfer resumes on the cycle out_ready returns.
- **Parallel independent allocation:**
  - Stimulus: X→Y and Y→X headers in the same cycle.
  - Required: both outputs lock at the next edge, with sel_y=01 and sel_x=10.
- **Destination NONE and reset mid-packet:**
  - Stimulus: in_dir_local=00 while valid; separately, assert rst_n during beat 2 of an X→LOCAL packet.
  - Required: the NONE input is never granted and shows fail[0]=1. After reset, all sel_*=00, and the next header is arbitrated from pointer X.
- **Timeout (ALLOC_TIMEOUT_EN, TIMEOUT=4):**
  - Stimulus: lock X→Y, then drop in_valid[2] with out_ready held at 1.
  - Required: timeout_err[1] pulses one cycle at the 4th idle cycle, and Y out returns to IDLE.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants: direction/select codes, port bit indices and allocator FSM states.
package router_pkg;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_X     = 2'b01;
    localparam logic [1:0] DIR_Y     = 2'b10;
    localparam logic [1:0] DIR_LOCAL = 2'b11;

    localparam int PORT_X     = 2;
    localparam int PORT_Y     = 1;
    localparam int PORT_LOCAL = 0;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_e;

    // One-hot port-bit mask for a select code; NONE maps to no port.
    function automatic logic [2:0] port_mask(input logic [1:0] code);
        return (code == DIR_NONE) ? 3'b000 : (3'b001 << (~code));
    endfunction

    // Round-robin successor in the X -> Y -> LOCAL -> X search order.
    function automatic logic [1:0] next_dir(input logic [1:0] code);
        return (code == DIR_LOCAL) ? DIR_X : code + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin pick for one output: search starts at ptr and the first requester wins.
module rr_arb3
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       gnt
);

    logic [1:0] cand;

    always_comb begin
        winner = DIR_NONE;
        gnt    = 1'b0;
        cand   = (ptr == DIR_NONE) ? DIR_X : ptr;
        for (int j = 0; j < 3; j++) begin
            if (!gnt && |(req & port_mask(cand))) begin
                gnt    = 1'b1;
                winner = cand;
            end
            cand = next_dir(cand);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole output allocator for the 3-port router: one IDLE/LOCKED FSM and rr_arb3 per output.
// Optional idle-lock watchdog enabled by defining ALLOC_TIMEOUT_EN.
module switch_allocator
    import router_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in_valid,
    input  logic [1:0] in_dir_x,
    input  logic [1:0] in_dir_y,
    input  logic [1:0] in_dir_local,
    input  logic [2:0] in_tail,
    input  logic [2:0] out_ready,
    output logic [2:0] in_ready,
    output logic [2:0] out_valid,
    output logic [1:0] sel_x,
    output logic [1:0] sel_y,
    output logic [1:0] sel_local,
    output logic [2:0] fail
`ifdef ALLOC_TIMEOUT_EN
    ,
    output logic [2:0] timeout_err
`endif
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("switch_allocator: TIMEOUT must be 1..255");
    end

    logic [2:0][1:0] dir;
    logic [2:0][1:0] owner;
    logic [2:0][1:0] sel;
    logic [2:0]      locked;
    logic [2:0]      busy;

    assign dir[PORT_X]     = in_dir_x;
    assign dir[PORT_Y]     = in_dir_y;
    assign dir[PORT_LOCAL] = in_dir_local;

    // An input already holding an output may not request another.
    always_comb begin
        busy     = '0;
        in_ready = '0;
        for (int o = 0; o < 3; o++) begin
            if (locked[o]) begin
                busy     = busy | port_mask(owner[o]);
                in_ready = in_ready | (port_mask(owner[o]) & {3{out_ready[o]}});
            end
        end
    end

    assign fail = in_valid & ~in_ready;

    for (genvar o = 0; o < 3; o++) begin : g_out
        localparam logic [1:0] CODE = 2'(3 - o);

        alloc_state_e state;
        logic [1:0]   own_q, ptr_q, win;
        logic [2:0]   req;
        logic         gnt, src_valid, src_tail, xfer, tmo;

        always_comb begin
            req = '0;
            for (int i = 0; i < 3; i++)
                req[i] = in_valid[i] && !busy[i] && (dir[i] == CODE);
        end

        rr_arb3 u_arb (
            .req    (req),
            .ptr    (ptr_q),
            .winner (win),
            .gnt    (gnt)
        );

        assign locked[o]    = (state == LOCKED);
        assign owner[o]     = own_q;
        assign src_valid    = |(in_valid & port_mask(own_q));
        assign src_tail     = |(in_tail & port_mask(own_q));
        assign xfer         = locked[o] && src_valid && out_ready[o];
        assign out_valid[o] = locked[o] && src_valid;
        assign sel[o]       = locked[o] ? own_q : DIR_NONE;

`ifdef ALLOC_TIMEOUT_EN
        logic [7:0] cnt;
        logic       starved;

        // Only an absent owner flit counts; downstream backpressure never does.
        assign starved        = locked[o] && !src_valid;
        assign tmo            = starved && (cnt == 8'(TIMEOUT - 1));
        assign timeout_err[o] = tmo;

        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n)               cnt <= '0;
            else if (!locked[o])     cnt <= '0;
            else if (xfer || tmo)    cnt <= '0;
            else if (starved)        cnt <= cnt + 8'd1;
        end
`else
        assign tmo = 1'b0;
`endif

        // Pointer moves past the winner at grant, so a released owner ranks last next time.
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                state <= IDLE;
                own_q <= DIR_NONE;
                ptr_q <= DIR_X;
            end else if (!locked[o]) begin
                if (gnt) begin
                    state <= LOCKED;
                    own_q <= win;
                    ptr_q <= next_dir(win);
                end
            end else if ((xfer && src_tail) || tmo) begin
                state <= IDLE;
                own_q <= DIR_NONE;
            end
        end
    end

    assign sel_x     = sel[PORT_X];
    assign sel_y     = sel[PORT_Y];
    assign sel_local = sel[PORT_LOCAL];

endmodule

// File: tb/tb_switch_allocator.sv
// Directed + random bench for switch_allocator against a per-output owner/pointer reference model.
module tb_switch_allocator;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_valid, in_tail, out_ready;
    logic [1:0] in_dir_x, in_dir_y, in_dir_local;
    logic [2:0] in_ready, out_valid, fail;
    logic [1:0] sel_x, sel_y, sel_local;
`ifdef ALLOC_TIMEOUT_EN
    logic [2:0] timeout_err;
`endif

    int errors = 0;
    int checks = 0;

    // Model: own[o] = input port bit owning output o (-1 when idle); ptr[o] = port bit where search starts.
    int own[3];
    int ptr[3];

    switch_allocator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_dir_x     (in_dir_x),
        .in_dir_y     (in_dir_y),
        .in_dir_local (in_dir_local),
        .in_tail      (in_tail),
        .out_ready    (out_ready),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .sel_x        (sel_x),
        .sel_y        (sel_y),
        .sel_local    (sel_local),
        .fail         (fail)
`ifdef ALLOC_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nxt(input int p);
        return (p == 0) ? 2 : p - 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 3; o++) begin
            own[o] = -1;
            ptr[o] = 2;
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] er, ev, ef;
        logic [5:0] es;
        er = '0; ev = '0; es = '0;
        for (int o = 0; o < 3; o++) begin
            if (own[o] >= 0) begin
                er[own[o]]  = out_ready[o];
                ev[o]       = in_valid[own[o]];
                es[o*2 +: 2] = 2'(3 - own[o]);
            end
        end
        ef = in_valid & ~er;
        chk({tag, ".in_ready"}, {5'd0, in_ready}, {5'd0, er});
        chk({tag, ".out_valid"}, {5'd0, out_valid}, {5'd0, ev});
        chk({tag, ".sel"}, {2'd0, sel_x, sel_y, sel_local}, {2'd0, es});
        chk({tag, ".fail"}, {5'd0, fail}, {5'd0, ef});
    endtask

    task automatic apply(input string tag, input logic [2:0] v, input logic [1:0] dx,
                         input logic [1:0] dy, input logic [1:0] dl,
                         input logic [2:0] t, input logic [2:0] r);
        in_valid = v; in_dir_x = dx; in_dir_y = dy; in_dir_local = dl;
        in_tail = t; out_ready = r;
        #2;
        check_all(tag);
    endtask

    task automatic tick();
        int  nown[3], nptr[3], d[3];
        bit  busy[3];
        bit  found;
        int  p;
        @(posedge clk);
        if (rst_n) begin
            model_reset();
        end else begin
            d[2] = int'(in_dir_x); d[1] = int'(in_dir_y); d[0] = int'(in_dir_local);
            for (int i = 0; i < 3; i++) busy[i] = 1'b0;
            for (int o = 0; o < 3; o++) if (own[o] >= 0) busy[own[o]] = 1'b1;
            for (int o = 0; o < 3; o++) begin
                nown[o] = own[o];
                nptr[o] = ptr[o];
                if (own[o] >= 0) begin
                    if (in_valid[own[o]] && out_ready[o] && in_tail[own[o]]) nown[o] = -1;
                end else begin
                    p = ptr[o];
                    found = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        if (!found && in_valid[p] && !busy[p] && d[p] == 3 - o) begin
                            found   = 1'b1;
                            nown[o] = p;
                            nptr[o] = nxt(p);
                        end
                        p = nxt(p);
                    end
                end
            end
            for (int o = 0; o < 3; o++) begin
                own[o] = nown[o];
                ptr[o] = nptr[o];
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = '0; in_tail = '0; out_ready = '0;
        in_dir_x = '0; in_dir_y = '0; in_dir_local = '0;
        model_reset();
        @(negedge clk);

        // Reset state
        apply("rst", 3'b101, 2'b10, 2'b00, 2'b11, 3'b000, 3'b111);
        chk("rst.fail_eq_valid", {5'd0, fail}, 8'h05);
        tick();
        rst_n = 1'b0;

        // Three-way contention for Y out with single-flit packets
        apply("c0", 3'b111, 2'b10, 2'b10, 2'b10, 3'b111, 3'b111); tick();
        apply("c1", 3'b111, 2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("c1.sel_y", {6'd0, sel_y}, 8'h01);
        chk("c1.fail", {5'd0, fail}, 8'h03);
        tick();
        apply("c2", 3'b011, 2'b10, 2'b10, 2'b10, 3'b111, 3'b111); tick();
        apply("c3", 3'b011, 2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("c3.sel_y", {6'd0, sel_y}, 8'h02);
        chk("c3.fail", {5'd0, fail}, 8'h01);
        tick();
        apply("c4", 3'b001, 2'b10, 2'b10, 2'b10, 3'b111, 3'b111); tick();
        apply("c5", 3'b001, 2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("c5.sel_y", {6'd0, sel_y}, 8'h03);
        chk("c5.fail", {5'd0, fail}, 8'h00);
        tick();
        apply("c6", 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b111); tick();

        // Wormhole hold: X sends 4 flits to LOCAL, Y joins at beat 2
        apply("w0", 3'b100, 2'b11, 2'b00, 2'b00, 3'b000, 3'b111); tick();
        apply("w1", 3'b100, 2'b11, 2'b00, 2'b00, 3'b000, 3'b111);
        chk("w1.sel_local", {6'd0, sel_local}, 8'h01);
        tick();
        for (int b = 2; b <= 4; b++) begin
            apply("wb", 3'b110, 2'b00, 2'b11, 2'b00, (b == 4) ? 3'b100 : 3'b000, 3'b111);
            chk("wb.sel_local", {6'd0, sel_local}, 8'h01);
            chk("wb.fail_y", {7'd0, fail[1]}, 8'h01);
            tick();
        end
        apply("w5", 3'b010, 2'b00, 2'b11, 2'b00, 3'b000, 3'b111);
        chk("w5.bubble", {6'd0, sel_local}, 8'h00);
        tick();
        apply("w6", 3'b010, 2'b00, 2'b11, 2'b00, 3'b010, 3'b111);
        chk("w6.sel_local", {6'd0, sel_local}, 8'h02);
        tick();

        // Backpressure on a locked X->Y transfer
        apply("b0", 3'b100, 2'b10, 2'b00, 2'b00, 3'b000, 3'b111); tick();
        for (int k = 0; k < 5; k++) begin
            apply("bp", 3'b100, 2'b10, 2'b00, 2'b00, 3'b000, 3'b101);
            chk("bp.in_ready_x", {7'd0, in_ready[2]}, 8'h00);
            chk("bp.sel_y", {6'd0, sel_y}, 8'h01);
            tick();
        end
        apply("b6", 3'b100, 2'b10, 2'b00, 2'b00, 3'b100, 3'b111);
        chk("b6.resume", {5'd0, in_ready}, 8'h04);
        tick();

        // Parallel independent allocation X->Y and Y->X
        apply("p0", 3'b110, 2'b10, 2'b01, 2'b00, 3'b110, 3'b111); tick();
        apply("p1", 3'b110, 2'b10, 2'b01, 2'b00, 3'b110, 3'b111);
        chk("p1.sel_xy", {4'd0, sel_x, sel_y}, 8'h09);
        tick();

        // Destination NONE never granted
        for (int k = 0; k < 3; k++) begin
            apply("n", 3'b001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b111);
            chk("n.fail", {5'd0, fail}, 8'h01);
            tick();
        end

        // Reset mid-packet on X->LOCAL, then X and Y contend from pointer X
        apply("r0", 3'b100, 2'b11, 2'b00, 2'b00, 3'b000, 3'b111); tick();
        apply("r1", 3'b100, 2'b11, 2'b00, 2'b00, 3'b000, 3'b111); tick();
        apply("r2", 3'b100, 2'b11, 2'b00, 2'b00, 3'b000, 3'b111);
        rst_n = 1'b1;
        #1;
        model_reset();
        check_all("r2rst");
        chk("r2rst.sel", {2'd0, sel_x, sel_y, sel_local}, 8'h00);
        tick();
        rst_n = 1'b0;
        apply("r3", 3'b110, 2'b11, 2'b11, 2'b00, 3'b000, 3'b111); tick();
        apply("r4", 3'b110, 2'b11, 2'b11, 2'b00, 3'b000, 3'b111);
        chk("r4.sel_local", {6'd0, sel_local}, 8'h01);
        tick();

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            apply("rnd", 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  3'($urandom) & 3'($urandom), 3'($urandom) | 3'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
